// File: rtl/cmp_stream.sv
// Two-stage pipelined magnitude comparator for streamed operand pairs, with
// saturating outcome counters and a running min/max tracker of x.
module cmp_stream #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             signed_mode,
  input  logic             clr,
  output logic             out_valid,
  output logic             xgy,
  output logic             xsy,
  output logic             xey,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [CNT_W-1:0] lt_cnt,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [WIDTH-1:0] x_max,
  output logic [WIDTH-1:0] x_min,
  output logic             trk_valid
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_x;
  logic [WIDTH-1:0] r_s1_y;
  logic             r_s1_signed;
  logic [WIDTH-1:0] r_s2_x;
  logic             r_s2_signed;

  logic [WIDTH-1:0] w_s1_msk;
  logic [WIDTH-1:0] w_cmp_a;
  logic [WIDTH-1:0] w_cmp_b;
  logic [WIDTH-1:0] w_s2_msk;
  logic [WIDTH-1:0] w_trk_x;
  logic [WIDTH-1:0] w_trk_max;
  logic [WIDTH-1:0] w_trk_min;

  // Flipping the MSB maps two's-complement order onto unsigned order.
  assign w_s1_msk = {r_s1_signed, {(WIDTH-1){1'b0}}};
  assign w_cmp_a  = r_s1_x ^ w_s1_msk;
  assign w_cmp_b  = r_s1_y ^ w_s1_msk;

  assign w_s2_msk  = {r_s2_signed, {(WIDTH-1){1'b0}}};
  assign w_trk_x   = r_s2_x ^ w_s2_msk;
  assign w_trk_max = x_max ^ w_s2_msk;
  assign w_trk_min = x_min ^ w_s2_msk;

  // Capture stage.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its sources, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_x      <= '0;
      r_s1_y      <= '0;
      r_s1_signed <= 1'b0;
    end else begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_x      <= x;
        r_s1_y      <= y;
        r_s1_signed <= signed_mode;
      end
    end
  end

  // Compare stage: flags hold their last value while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      xgy         <= 1'b0;
      xsy         <= 1'b0;
      xey         <= 1'b0;
      r_s2_x      <= '0;
      r_s2_signed <= 1'b0;
    end else begin
      out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        xgy         <= (w_cmp_a > w_cmp_b);
        xsy         <= (w_cmp_a < w_cmp_b);
        xey         <= (w_cmp_a == w_cmp_b);
        r_s2_x      <= r_s1_x;
        r_s2_signed <= r_s1_signed;
      end
    end
  end

  // Outcome counters: clr wins over a result completing in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gt_cnt <= '0;
      lt_cnt <= '0;
      eq_cnt <= '0;
    end else if (clr) begin
      gt_cnt <= '0;
      lt_cnt <= '0;
      eq_cnt <= '0;
    end else if (out_valid) begin
      if (xgy && gt_cnt != CNT_MAX) gt_cnt <= gt_cnt + 1'b1;
      if (xsy && lt_cnt != CNT_MAX) lt_cnt <= lt_cnt + 1'b1;
      if (xey && eq_cnt != CNT_MAX) eq_cnt <= eq_cnt + 1'b1;
    end
  end

  // Min/max tracker, each update interpreted with its own sample's signedness.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_max     <= '0;
      x_min     <= '0;
      trk_valid <= 1'b0;
    end else if (clr) begin
      x_max     <= '0;
      x_min     <= '0;
      trk_valid <= 1'b0;
    end else if (out_valid) begin
      if (!trk_valid) begin
        x_max     <= r_s2_x;
        x_min     <= r_s2_x;
        trk_valid <= 1'b1;
      end else begin
        if (w_trk_x > w_trk_max) x_max <= r_s2_x;
        if (w_trk_x < w_trk_min) x_min <= r_s2_x;
      end
    end
  end

endmodule

// File: tb/tb_cmp_stream.sv
// Directed self-checking bench for cmp_stream: a default instance plus a
// CNT_W=2 instance sharing the same stimulus for saturation.
module tb_cmp_stream;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         signed_mode;
  logic         clr;

  logic         out_valid, xgy, xsy, xey, trk_valid;
  logic [15:0]  gt_cnt, lt_cnt, eq_cnt;
  logic [W-1:0] x_max, x_min;

  logic         s_out_valid, s_xgy, s_xsy, s_xey, s_trk_valid;
  logic [1:0]   s_gt_cnt, s_lt_cnt, s_eq_cnt;
  logic [W-1:0] s_x_max, s_x_min;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  cmp_stream #(.WIDTH(W), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .x(x), .y(y),
    .signed_mode(signed_mode), .clr(clr), .out_valid(out_valid),
    .xgy(xgy), .xsy(xsy), .xey(xey), .gt_cnt(gt_cnt), .lt_cnt(lt_cnt),
    .eq_cnt(eq_cnt), .x_max(x_max), .x_min(x_min), .trk_valid(trk_valid)
  );

  cmp_stream #(.WIDTH(W), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .x(x), .y(y),
    .signed_mode(signed_mode), .clr(clr), .out_valid(s_out_valid),
    .xgy(s_xgy), .xsy(s_xsy), .xey(s_xey), .gt_cnt(s_gt_cnt), .lt_cnt(s_lt_cnt),
    .eq_cnt(s_eq_cnt), .x_max(s_x_max), .x_min(s_x_min), .trk_valid(s_trk_valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic s, input logic c);
    in_valid    = v;
    x           = a;
    y           = b;
    signed_mode = s;
    clr         = c;
  endtask

  // Advance one edge; outputs are sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic c);
    drive(1'b0, '0, '0, 1'b0, c);
  endtask

  initial begin
    rst_n = 1'b0;
    idle(1'b0);
    tick();
    tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_flags", {xgy, xsy, xey}, 3'b000);
    check("rst_cnts", {gt_cnt, lt_cnt, eq_cnt}, 0);
    check("rst_trk", {trk_valid, x_max, x_min}, 0);
    rst_n = 1'b1;
    tick();

    // Unsigned: gt, lt, eq on consecutive cycles.
    drive(1'b1, 8'd5, 8'd3, 1'b0, 1'b0);     tick();
    check("u_ov_before", out_valid, 0);
    drive(1'b1, 8'd3, 8'd5, 1'b0, 1'b0);     tick();
    check("u_gt", {out_valid, xgy, xsy, xey}, 4'b1100);
    drive(1'b1, 8'd200, 8'd200, 1'b0, 1'b0); tick();
    check("u_lt", {out_valid, xgy, xsy, xey}, 4'b1010);
    idle(1'b0);                              tick();
    check("u_eq", {out_valid, xgy, xsy, xey}, 4'b1001);
    tick();
    check("u_ov_drop", out_valid, 0);
    check("u_flags_hold", {xgy, xsy, xey}, 3'b001);
    check("u_cnts", {gt_cnt, lt_cnt, eq_cnt}, {16'd1, 16'd1, 16'd1});

    // Signed vs unsigned interpretation of FF vs 01.
    drive(1'b1, 8'hFF, 8'h01, 1'b1, 1'b0);   tick();
    drive(1'b1, 8'hFF, 8'h01, 1'b0, 1'b0);   tick();
    check("s_lt", {out_valid, xgy, xsy, xey}, 4'b1010);
    idle(1'b0);                              tick();
    check("us_gt", {out_valid, xgy, xsy, xey}, 4'b1100);
    tick();
    check("s_cnts", {gt_cnt, lt_cnt, eq_cnt}, {16'd2, 16'd2, 16'd1});

    // Tracker, unsigned stream.
    idle(1'b1); tick();
    idle(1'b0);
    check("clr_cnts", {gt_cnt, lt_cnt, eq_cnt}, 0);
    check("clr_trk", trk_valid, 0);
    drive(1'b1, 8'd10, 8'd0, 1'b0, 1'b0);  tick();
    drive(1'b1, 8'd250, 8'd0, 1'b0, 1'b0); tick();
    drive(1'b1, 8'd3, 8'd0, 1'b0, 1'b0);   tick();
    drive(1'b1, 8'd7, 8'd0, 1'b0, 1'b0);   tick();
    idle(1'b0); tick(); tick(); tick();
    check("trk_max", x_max, 250);
    check("trk_min", x_min, 3);
    check("trk_valid", trk_valid, 1);
    check("trk_gt_cnt", gt_cnt, 4);
    idle(1'b1); tick();
    idle(1'b0);
    check("trk_clr", {trk_valid, x_max, x_min}, 0);

    // Tracker, signed stream: -5 and 3.
    drive(1'b1, 8'hFB, 8'd0, 1'b1, 1'b0); tick();
    drive(1'b1, 8'd3, 8'd0, 1'b1, 1'b0);  tick();
    idle(1'b0); tick(); tick();
    check("strk_max", x_max, 8'd3);
    check("strk_min", x_min, 8'hFB);
    check("strk_lt_cnt", lt_cnt, 1);

    // Saturation on the CNT_W=2 instance.
    idle(1'b1); tick();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'd7, 8'd7, 1'b0, 1'b0);
      tick();
    end
    check("sat_eq_after3", s_eq_cnt, 3);
    check("wide_eq_after3", eq_cnt, 3);
    idle(1'b0); tick(); tick(); tick();
    check("sat_eq_hold", s_eq_cnt, 3);
    check("wide_eq_final", eq_cnt, 5);

    // clr coinciding with an out_valid gt result.
    idle(1'b1); tick();
    drive(1'b1, 8'd9, 8'd1, 1'b0, 1'b0); tick();
    idle(1'b0);                          tick();
    check("cc_flags", {out_valid, xgy}, 2'b11);
    idle(1'b1);                          tick();
    idle(1'b0);
    check("cc_gt_cnt", gt_cnt, 0);
    check("cc_trk", trk_valid, 0);
    drive(1'b1, 8'd9, 8'd1, 1'b0, 1'b0); tick();
    idle(1'b0); tick(); tick();
    check("cc_next_gt", gt_cnt, 1);

    // Async reset with two pairs in flight.
    drive(1'b1, 8'd4, 8'd2, 1'b0, 1'b0); tick();
    drive(1'b1, 8'd1, 8'd8, 1'b0, 1'b0); tick();
    check("ar_pre_ov", out_valid, 1);
    idle(1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("ar_ov", out_valid, 0);
    check("ar_flags", {xgy, xsy, xey}, 0);
    check("ar_cnts", {gt_cnt, lt_cnt, eq_cnt}, 0);
    check("ar_trk", {trk_valid, x_max, x_min}, 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ar_no_ov", out_valid, 0);
    end
    drive(1'b1, 8'd2, 8'd2, 1'b0, 1'b0); tick();
    idle(1'b0);                          tick();
    check("ar_new_eq", {out_valid, xey}, 2'b11);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
